// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqCpu = 1'b0,
    ReqIo  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_req_mux.sv
// Combinational 2:1 selection of a requester command {we, addr, wdata} by requester ID.
module mem_req_mux
  import mem_arb_pkg::*;
#(
  parameter int unsigned d  = 16,
  parameter int unsigned aw = 12
) (
  input  req_id_e         sel,
  input  logic            cpu_we,
  input  logic [aw-1:0]   cpu_addr,
  input  logic [d-1:0]    cpu_wdata,
  input  logic            io_we,
  input  logic [aw-1:0]   io_addr,
  input  logic [d-1:0]    io_wdata,
  output logic            sel_we,
  output logic [aw-1:0]   sel_addr,
  output logic [d-1:0]    sel_wdata
);

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (sel == ReqIo) begin
      sel_we    = io_we;
      sel_addr  = io_addr;
      sel_wdata = io_wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a loader/DMA port,
// with an IO lock that lets the loader hold the memory across a multi-word burst.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned d  = 16,
  parameter int unsigned aw = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [aw-1:0] cpu_addr,
  input  logic [d-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [d-1:0]  cpu_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [aw-1:0] io_addr,
  input  logic [d-1:0]  io_wdata,
  output logic          io_gnt,
  output logic          io_rvalid,
  output logic [d-1:0]  io_rdata,
  input  logic          io_lock,
  output logic [aw-1:0] mem_addr,
  output logic          mem_we,
  output logic [d-1:0]  mem_wdata,
  input  logic [d-1:0]  mem_rdata,
  output logic          busy
);

  arb_state_e    r_state;
  req_id_e       r_last;
  req_id_e       r_owner;
  logic          r_lock;
  logic          r_cpu_gnt, r_io_gnt;
  logic          r_cpu_rvalid, r_io_rvalid;
  logic [aw-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [d-1:0]  r_mem_wdata;

  logic          w_cpu_elig, w_io_elig, w_any;
  req_id_e       w_win;
  logic          w_we;
  logic [aw-1:0] w_addr;
  logic [d-1:0]  w_wdata;

  // A lock only blocks the CPU while io_lock is still high; dropping io_lock releases
  // the lock and lets the CPU compete at that very edge.
  assign w_cpu_elig = cpu_req & ~(r_lock & io_lock);
  assign w_io_elig  = io_req;
  assign w_any      = w_cpu_elig | w_io_elig;

  always_comb begin
    w_win = ReqIo;
    if (w_cpu_elig && w_io_elig) begin
      w_win = (r_last == ReqIo) ? ReqCpu : ReqIo;
    end else if (w_cpu_elig) begin
      w_win = ReqCpu;
    end
  end

  mem_req_mux #(
    .d  (d),
    .aw (aw)
  ) u_mux (
    .sel       (w_win),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .sel_we    (w_we),
    .sel_addr  (w_addr),
    .sel_wdata (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_last       <= ReqIo;
      r_owner      <= ReqCpu;
      r_lock       <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_io_gnt     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!io_lock) begin
            r_lock <= 1'b0;
          end
          if (w_any) begin
            r_mem_addr  <= w_addr;
            r_mem_we    <= w_we;
            r_mem_wdata <= w_wdata;
            r_owner     <= w_win;
            r_last      <= w_win;
            r_cpu_gnt   <= (w_win == ReqCpu);
            r_io_gnt    <= (w_win == ReqIo);
            if (w_win == ReqIo && io_lock) begin
              r_lock <= 1'b1;
            end
            r_state <= StAccess;
          end else begin
            r_mem_we <= 1'b0;
          end
        end
        StAccess: begin
          r_cpu_gnt <= 1'b0;
          r_io_gnt  <= 1'b0;
          r_mem_we  <= 1'b0;
          if (r_mem_we) begin
            r_state <= StIdle;
          end else begin
            r_cpu_rvalid <= (r_owner == ReqCpu);
            r_io_rvalid  <= (r_owner == ReqIo);
            r_state      <= StResp;
          end
        end
        StResp: begin
          r_cpu_rvalid <= 1'b0;
          r_io_rvalid  <= 1'b0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign io_gnt     = r_io_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign io_rvalid  = r_io_rvalid;
  // Memory output is valid during RESP, so read data is gated straight through.
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
  assign io_rdata   = r_io_rvalid ? mem_rdata : '0;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous single-port memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        io_req, io_we;
  logic [11:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_gnt, io_rvalid;
  logic [15:0] io_rdata;
  logic        io_lock;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  logic [15:0] mem [4096];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .d  (16),
    .aw (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_rdata   (io_rdata),
    .io_lock    (io_lock),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'h1234;
    mem_rdata = 16'h0000;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0; io_lock = 0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state, then CPU read of 0x010
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_io_gnt", io_gnt, 0);
    chk("rst_rvalid", {cpu_rvalid, io_rvalid}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    tick();
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_io_gnt", io_gnt, 0);
    chk("t1_mem_addr", mem_addr, 12'h010);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    cpu_req = 0;
    tick();
    chk("t1_gnt_clr", cpu_gnt, 0);
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 16'h1234);
    chk("t1_io_rdata", io_rdata, 0);
    tick();
    chk("t1_rvalid_clr", cpu_rvalid, 0);
    chk("t1_rdata_clr", cpu_rdata, 0);
    chk("t1_busy_low", busy, 0);

    // 2: IO write then CPU readback
    io_req = 1; io_we = 1; io_addr = 12'h020; io_wdata = 16'hBEEF;
    tick();
    chk("t2_io_gnt", io_gnt, 1);
    chk("t2_cpu_gnt", cpu_gnt, 0);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 12'h020);
    chk("t2_mem_wdata", mem_wdata, 16'hBEEF);
    io_req = 0;
    tick();
    chk("t2_mem_we_clr", mem_we, 0);
    chk("t2_io_gnt_clr", io_gnt, 0);
    chk("t2_busy_low", busy, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
    tick();
    chk("t2_cpu_gnt", cpu_gnt, 1);
    chk("t2_rd_we", mem_we, 0);
    cpu_req = 0;
    tick();
    chk("t2_rvalid", cpu_rvalid, 1);
    chk("t2_rdata", cpu_rdata, 16'hBEEF);
    tick();

    // 3: continuous contention alternates starting with CPU after reset
    reset = 1; tick(); reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h030; cpu_wdata = 16'h1111;
    io_req = 1; io_we = 1; io_addr = 12'h031; io_wdata = 16'h2222;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t3_cpu_gnt_%0d", k), cpu_gnt, (k == 1 || k == 5) ? 1 : 0);
      chk($sformatf("t3_io_gnt_%0d", k), io_gnt, (k == 3 || k == 7) ? 1 : 0);
      chk($sformatf("t3_excl_%0d", k), cpu_gnt & io_gnt, 0);
    end
    cpu_req = 0; io_req = 0;
    chk("t3_mem_cpu", mem[12'h030], 16'h1111);
    chk("t3_mem_io", mem[12'h031], 16'h2222);

    // 4: IO lock burst holds off a waiting CPU; a CPU write first makes IO win the tie
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_wdata = 16'h4444;
    tick();
    chk("t4_pre_gnt", cpu_gnt, 1);
    cpu_we = 0; cpu_addr = 12'h010;
    tick();
    io_req = 1; io_we = 1; io_lock = 1;
    for (int i = 0; i < 4; i++) begin
      io_addr = 12'h100 + 12'(i); io_wdata = 16'hA000 + 16'(i);
      tick();
      chk($sformatf("t4_io_gnt_%0d", i), io_gnt, 1);
      chk($sformatf("t4_cpu_hold_%0d", i), cpu_gnt, 0);
      chk($sformatf("t4_addr_%0d", i), mem_addr, 12'h100 + 12'(i));
      if (i == 3) begin
        io_req = 0; io_lock = 0;
      end
      tick();
      chk($sformatf("t4_cpu_hold_b_%0d", i), cpu_gnt, 0);
    end
    tick();
    chk("t4_cpu_after_unlock", cpu_gnt, 1);
    chk("t4_io_idle", io_gnt, 0);
    cpu_req = 0;
    tick();
    chk("t4_rdata", cpu_rdata, 16'h1234);
    tick();
    chk("t4_mem_100", mem[12'h100], 16'hA000);
    chk("t4_mem_103", mem[12'h103], 16'hA003);

    // 5: reset during RESP abandons the read and restores CPU tie priority
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    tick();
    chk("t5_gnt", cpu_gnt, 1);
    cpu_req = 0;
    tick();
    chk("t5_in_resp", cpu_rvalid, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_rvalid_rst", cpu_rvalid, 0);
    chk("t5_rdata_rst", cpu_rdata, 0);
    chk("t5_busy_rst", busy, 0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h050; cpu_wdata = 16'h5555;
    io_req = 1; io_we = 1; io_addr = 12'h051; io_wdata = 16'h5151;
    tick();
    chk("t5_tie_cpu", cpu_gnt, 1);
    chk("t5_tie_io", io_gnt, 0);
    cpu_req = 0;
    tick();
    chk("t5_no_gnt_access", cpu_gnt | io_gnt, 0);
    tick();
    chk("t5_io_next", io_gnt, 1);
    io_req = 0;
    tick();

    // 6: req held past gnt, read then write
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    tick();
    chk("t6_gnt1", cpu_gnt, 1);
    cpu_we = 1; cpu_addr = 12'h060; cpu_wdata = 16'h6666;
    tick();
    chk("t6_no_dup_access", cpu_gnt, 0);
    chk("t6_rdata", cpu_rdata, 16'h1234);
    tick();
    chk("t6_no_dup_resp", cpu_gnt, 0);
    chk("t6_rvalid_clr", cpu_rvalid, 0);
    tick();
    chk("t6_gnt2", cpu_gnt, 1);
    chk("t6_we2", mem_we, 1);
    chk("t6_addr2", mem_addr, 12'h060);
    cpu_req = 0;
    tick();
    chk("t6_we_clr", mem_we, 0);
    chk("t6_mem_060", mem[12'h060], 16'h6666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
